// File: rtl/weight_loader.sv
// weight_loader: streams BIT_SIZE-bit weight words into the per-node weight
// memory, node index fastest and layer index slowest, and pulses done on the
// final write.
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to build the running
// modulo-2^BIT_SIZE checksum of accepted words; otherwise checksum is tied to 0.
//
// Handshake: a word transfers on every rising edge where s_valid && s_ready.
// s_ready depends only on the FSM state (high in LOAD), never on s_valid, and
// s_valid is ignored whenever s_ready is low.
module weight_loader #(
  parameter int LAYER_SIZE  = 4,
  parameter int LAYER_DEPTH = 4,
  parameter int BIT_SIZE    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           s_valid,
  input  logic [BIT_SIZE-1:0]            s_data,
  output logic                           s_ready,
  output logic                           mem_write_enable,
  output logic [$clog2(LAYER_DEPTH)-1:0] mem_layer,
  output logic [$clog2(LAYER_SIZE)-1:0]  mem_node,
  output logic [BIT_SIZE-1:0]            mem_data,
  output logic                           busy,
  output logic                           done,
  output logic [BIT_SIZE-1:0]            checksum
);

  localparam int NW = $clog2(LAYER_SIZE);
  localparam int LW = $clog2(LAYER_DEPTH);
  localparam logic [NW-1:0] NODE_LAST  = NW'(LAYER_SIZE - 1);
  localparam logic [LW-1:0] LAYER_LAST = LW'(LAYER_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NW-1:0]       node_q, node_d;
  logic [LW-1:0]       layer_q, layer_d;
  logic                we_q, we_d;
  logic [LW-1:0]       mem_layer_q, mem_layer_d;
  logic [NW-1:0]       mem_node_q, mem_node_d;
  logic [BIT_SIZE-1:0] mem_data_q, mem_data_d;

  // Next-state, address counters and registered write port contents.
  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    layer_d     = layer_q;
    we_d        = 1'b0;
    mem_layer_d = mem_layer_q;
    mem_node_d  = mem_node_q;
    mem_data_d  = mem_data_q;
    s_ready     = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          node_d  = '0;
          layer_d = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // Address is captured at acceptance; the write lands next cycle.
          we_d        = 1'b1;
          mem_layer_d = layer_q;
          mem_node_d  = node_q;
          mem_data_d  = s_data;
          if (node_q == NODE_LAST) begin
            node_d = '0;
            if (layer_q == LAYER_LAST) begin
              // Final word: park the counters at 0 rather than overflow.
              layer_d = '0;
              state_d = LAST;
            end else begin
              layer_d = layer_q + LW'(1);
            end
          end else begin
            node_d = node_q + NW'(1);
          end
        end
      end
      LAST: begin
        // The last accepted word is being written this cycle.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      node_q      <= '0;
      layer_q     <= '0;
      we_q        <= 1'b0;
      mem_layer_q <= '0;
      mem_node_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      layer_q     <= layer_d;
      we_q        <= we_d;
      mem_layer_q <= mem_layer_d;
      mem_node_q  <= mem_node_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign mem_write_enable = we_q;
  assign mem_layer        = mem_layer_q;
  assign mem_node         = mem_node_q;
  assign mem_data         = mem_data_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [BIT_SIZE-1:0] checksum_q, checksum_d;

  // Running sum of accepted words, cleared when a new load starts.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && start) begin
      checksum_d = '0;
    end else if (state_q == LOAD && s_valid) begin
      checksum_d = checksum_q + s_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
